display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 20 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/display_scan_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package display_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int N_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} codes, entry 15 first down to entry 0
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with tear-free double buffering.
// Optional leading-zero blanking is built when DISPLAY_LZB_EN is defined.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 27000,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    output logic [3:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
    localparam logic [3:0]  GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit          HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [1:0]  IDX_LAST   = 2'(N_DIGITS - 1);

    state_t      state_reg, state_next;
    logic [19:0] presc_reg, presc_next;
    logic [3:0]  gap_reg, gap_next;
    logic [1:0]  idx_reg, idx_next;
    logic        advance;
    logic        wrap;

    // Buffers hold {dp[3:0], data[15:0]}
    logic [19:0] staging_reg;
    logic [19:0] shadow_reg;
    logic        pending_reg;

    logic [3:0]  nibble;
    logic [3:0]  dp_shadow;
    logic [6:0]  seg_dec;
    logic [6:0]  seg_show;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
            presc_reg <= '0;
            gap_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            gap_reg   <= gap_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        gap_next   = gap_reg;
        idx_next   = idx_reg;
        advance    = 1'b0;
        wrap       = 1'b0;
        if (!en_i) begin
            state_next = ST_OFF;
            presc_next = '0;
            gap_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_SHOW;
                    presc_next = '0;
                    idx_next   = '0;
                end
                ST_SHOW: begin
                    if (presc_reg == PRESC_LAST) begin
                        presc_next = '0;
                        if (HAS_GAP) begin
                            state_next = ST_GAP;
                            gap_next   = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        presc_next = presc_reg + 20'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        state_next = ST_SHOW;
                        gap_next   = '0;
                        advance    = 1'b1;
                    end else begin
                        gap_next = gap_reg + 4'd1;
                    end
                end
                default: state_next = ST_OFF;
            endcase
            if (advance) begin
                idx_next = idx_reg + 2'd1;
                wrap     = (idx_reg == IDX_LAST);
            end
        end
    end

    // Shadow only changes at a frame boundary (or while dark) so a frame never mixes old and new data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_reg <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (load_i && (state_reg == ST_OFF || wrap)) begin
            shadow_reg  <= {dp_i, data_i};
            pending_reg <= 1'b0;
        end else if (load_i) begin
            staging_reg <= {dp_i, data_i};
            pending_reg <= 1'b1;
        end else if (wrap && pending_reg) begin
            shadow_reg  <= staging_reg;
            pending_reg <= 1'b0;
        end
    end

    assign nibble    = shadow_reg[{idx_reg, 2'b00} +: 4];
    assign dp_shadow = shadow_reg[19:16];

    hex_to_7seg u_dec (
        .hex (nibble),
        .seg (seg_dec)
    );

`ifdef DISPLAY_LZB_EN
    logic [N_DIGITS-1:0] lz_blank;
    assign lz_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lzb
            assign lz_blank[gi] = (shadow_reg[15:4*gi] == '0);
        end
    endgenerate
    assign seg_show = lz_blank[idx_reg] ? SEG_BLANK : seg_dec;
`else
    assign seg_show = seg_dec;
`endif

    // Gating on en_i here lets the display go dark on the very next clock after disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_o <= 4'hF;
            seg_o   <= SEG_BLANK;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            frame_o <= wrap;
            if (en_i && state_reg == ST_SHOW) begin
                anode_o <= ~(4'b0001 << idx_reg);
                seg_o   <= seg_show;
                dp_o    <= ~dp_shadow[idx_reg];
            end else begin
                anode_o <= 4'hF;
                seg_o   <= SEG_BLANK;
                dp_o    <= 1'b1;
            end
        end
    end

endmodule
